// File: rtl/addrc_controller.sv
// addrc_controller: add-round-constant sequencer for the matrix encoder.
// Walks all DEPTH slices of the state in an external slice memory, doing a
// read / latch / write-back of each slice with the round-constant bit for
// (round, slice) XORed into bit 0 (lane (0,0)).
module addrc_controller #(
    parameter int N      = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int ROUNDS = 24,
    parameter int RND_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RND_W-1:0]  round_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [N-1:0]      mem_rdata,
    output logic              mem_wr,
    output logic [N-1:0]      mem_wdata,
    output logic [RND_W-1:0]  rc_round,
    output logic [ADDR_W-1:0] rc_slice,
    input  logic              rc_bit,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [RND_W-1:0]   round_q;
    logic [N-1:0]       slice_q;
    logic               rcb_q;
    logic               round_ok;

    // One extra bit on the compare so ROUNDS == 2^RND_W would still work.
    assign round_ok = ({1'b0, round_in} < (RND_W + 1)'(ROUNDS));

    // Addresses follow idx only while a pass is running; they sit at 0 in IDLE and FIN.
    assign mem_addr  = busy ? idx : '0;
    assign rc_slice  = mem_addr;
    assign rc_round  = round_q;
    assign mem_wdata = (state == S_WRITE) ? {slice_q[N-1:1], slice_q[0] ^ rcb_q} : '0;

    // Pass sequencer: state, slice counter, holding registers and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            idx     <= '0;
            round_q <= '0;
            slice_q <= '0;
            rcb_q   <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each is a single-cycle pulse;
            // all state here uses <= so every branch sees pre-edge values.
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (round_ok) begin
                            round_q <= round_in;
                            idx     <= '0;
                            mem_rd  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= S_READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    // Read data arrives during LATCH.
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    slice_q <= mem_rdata;
                    rcb_q   <= rc_bit;
                    mem_wr  <= 1'b1;
                    state   <= S_WRITE;
                end
                S_WRITE: begin
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        idx    <= idx + 1'b1;
                        mem_rd <= 1'b1;
                        state  <= S_READ;
                    end
                end
                S_FIN: begin
                    // Start is not looked at here, so it cannot be queued.
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addrc_controller.sv
// tb_addrc_controller: directed-vector bench for addrc_controller with a
// behavioural slice memory, a table-driven round-constant ROM and a
// protocol monitor.
module tb_addrc_controller;

    localparam int N      = 25;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int ROUNDS = 24;
    localparam int RND_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [RND_W-1:0]  round_in;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [N-1:0]      mem_rdata;
    logic              mem_wr;
    logic [N-1:0]      mem_wdata;
    logic [RND_W-1:0]  rc_round;
    logic [ADDR_W-1:0] rc_slice;
    logic              rc_bit;
    logic              busy;
    logic              done;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    addrc_controller #(
        .N(N), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROUNDS(ROUNDS), .RND_W(RND_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .round_in(round_in),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata), .rc_round(rc_round),
        .rc_slice(rc_slice), .rc_bit(rc_bit), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Slice memory: one-cycle read latency, bulk load from img when ld_en.
    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] img [DEPTH];
    logic         rom [DEPTH];
    logic         ld_en = 1'b0;

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= img[i];
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    assign rc_bit = rom[rc_slice];

    // Protocol monitor, sampled on the falling edge.
    logic              mon_clr = 1'b0;
    logic [RND_W-1:0]  exp_round = '0;
    int rd_cnt, wr_cnt, busy_cnt, done_cnt, err_cnt;
    int overlap, pair_err, order_err, rnd_err, slc_err, exp_wa;
    logic              rd_d1 = 1'b0, rd_d2 = 1'b0;
    logic [ADDR_W-1:0] rd_a1 = '0, rd_a2 = '0;

    always @(negedge clk) begin
        if (mon_clr) begin
            rd_cnt = 0; wr_cnt = 0; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
            overlap = 0; pair_err = 0; order_err = 0; rnd_err = 0; slc_err = 0;
            exp_wa = 0;
        end else begin
            if (mem_rd && mem_wr) overlap++;
            if (mem_rd) rd_cnt++;
            if (mem_wr) begin
                wr_cnt++;
                if (mem_addr != ADDR_W'(exp_wa)) order_err++;
                exp_wa++;
                if (!(rd_d2 && rd_a2 == mem_addr)) pair_err++;
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy && rc_round != exp_round) rnd_err++;
            if (rc_slice != mem_addr) slc_err++;
        end
        rd_d2 = rd_d1; rd_a2 = rd_a1;
        rd_d1 = mem_rd; rd_a1 = mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
    endtask

    task automatic load_mem();
        @(negedge clk); ld_en = 1'b1;
        @(negedge clk); ld_en = 1'b0;
    endtask

    // Pulse start with round r, then count falling edges until done (bounded).
    task automatic run_pass(input logic [RND_W-1:0] r, output int lat);
        @(negedge clk);
        start = 1'b1; round_in = r;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin lat = c; break; end
        end
    endtask

    // Number of slices in [lo,hi] whose content differs from img ^ flip.
    function automatic int count_bad(input int lo, input int hi, input logic flip);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (mem[i] !== (img[i] ^ N'(flip))) n++;
        return n;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_err"},   32'(err),       32'd0);
        check({tag, "_rdwr"},  32'({mem_rd, mem_wr}), 32'd0);
        check({tag, "_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_round"}, 32'(rc_round),  32'd0);
    endtask

    initial begin
        int lat;
        int hit;
        rst = 1'b1; start = 1'b0; round_in = '0;
        for (int i = 0; i < DEPTH; i++) begin img[i] = '0; rom[i] = 1'b0; end
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        // Test 1: zero memory, ROM bit only at slice 0, round 0.
        rom[0] = 1'b1;
        load_mem();
        clear_mon();
        exp_round = 5'd0;
        run_pass(5'd0, lat);
        check("t1_latency", 32'(lat), 32'd193);
        repeat (3) @(posedge clk);
        check("t1_slice0",  32'(mem[0]), 32'h0000001);
        check("t1_others",  32'(count_bad(1, DEPTH - 1, 1'b0)), 32'd0);
        check("t1_done_n",  32'(done_cnt), 32'd1);
        check("t1_wr_n",    32'(wr_cnt), 32'd64);
        check("t1_rd_n",    32'(rd_cnt), 32'd64);
        check("t1_busy_n",  32'(busy_cnt), 32'd192);
        check("t1_overlap", 32'(overlap), 32'd0);
        check("t1_rd2wr",   32'(pair_err), 32'd0);
        check("t1_order",   32'(order_err), 32'd0);
        check("t1_rcslice", 32'(slc_err), 32'd0);
        check("t1_err_n",   32'(err_cnt), 32'd0);

        // Test 2: alternating preload, all ROM bits set, last valid round.
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = 25'h1FFFFFE | N'(i % 2);
            rom[i] = 1'b1;
        end
        load_mem();
        clear_mon();
        exp_round = 5'd23;
        run_pass(5'd23, lat);
        check("t2_latency", 32'(lat), 32'd193);
        repeat (3) @(posedge clk);
        check("t2_toggled", 32'(count_bad(0, DEPTH - 1, 1'b1)), 32'd0);
        check("t2_slice1",  32'(mem[1]), 32'h1FFFFFE);
        check("t2_wr_n",    32'(wr_cnt), 32'd64);
        check("t2_order",   32'(order_err), 32'd0);
        check("t2_rcround", 32'(rnd_err), 32'd0);

        // Test 3: out-of-range rounds raise err and touch nothing.
        clear_mon();
        @(negedge clk); start = 1'b1; round_in = 5'd24;
        @(negedge clk); start = 1'b0;
        check("t3_err_hi", 32'(err), 32'd1);
        @(negedge clk);
        check("t3_err_lo", 32'(err), 32'd0);
        start = 1'b1; round_in = 5'd31;
        @(negedge clk); start = 1'b0;
        check("t3_err31",  32'(err), 32'd1);
        repeat (4) @(posedge clk);
        check("t3_err_n",  32'(err_cnt), 32'd2);
        check("t3_busy_n", 32'(busy_cnt), 32'd0);
        check("t3_mem_n",  32'(rd_cnt + wr_cnt), 32'd0);
        check("t3_done_n", 32'(done_cnt), 32'd0);

        // Test 4: start held through the pass, round_in changed mid-pass.
        clear_mon();
        exp_round = 5'd5;
        @(negedge clk);
        start = 1'b1; round_in = 5'd5;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 60) round_in = 5'd7;
            if (done) begin lat = c; break; end
        end
        check("t4_latency", 32'(lat), 32'd193);
        @(posedge clk);
        check("t4_done_n",  32'(done_cnt), 32'd1);
        check("t4_rd_n",    32'(rd_cnt), 32'd64);
        check("t4_rcround", 32'(rnd_err), 32'd0);
        exp_round = 5'd7;
        @(negedge clk);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_rd",   32'(mem_rd), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("t4_restart",   32'({busy, mem_rd}), 32'h3);
        check("t4_new_round", 32'(rc_round), 32'd7);
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done) begin hit = 1; break; end
        end
        check("t4_second_done", 32'(hit), 32'd1);

        // Test 5: reset in WRITE of slice 10, then a fresh full pass.
        for (int i = 0; i < DEPTH; i++) img[i] = 25'h0A5A5A0 ^ N'(i << 3);
        load_mem();
        clear_mon();
        exp_round = 5'd2;
        @(negedge clk); start = 1'b1; round_in = 5'd2;
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_wr && mem_addr == 6'd10) begin hit = 1; break; end
        end
        check("t5_reach_w10", 32'(hit), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("t5_rst");
        rst = 1'b0;
        @(negedge clk);
        check("t5_after_wr", 32'(mem_wr), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_done_lo",  32'(count_bad(0, 10, 1'b1)), 32'd0);
        check("t5_untouched", 32'(count_bad(11, DEPTH - 1, 1'b0)), 32'd0);
        clear_mon();
        exp_round = 5'd1;
        run_pass(5'd1, lat);
        check("t5_latency", 32'(lat), 32'd193);
        repeat (3) @(posedge clk);
        check("t5_lo_back", 32'(count_bad(0, 10, 1'b0)), 32'd0);
        check("t5_hi_flip", 32'(count_bad(11, DEPTH - 1, 1'b1)), 32'd0);
        check("t5_wr_n",    32'(wr_cnt), 32'd64);
        check("t5_order",   32'(order_err), 32'd0);
        check("t5_rd2wr",   32'(pair_err), 32'd0);
        check("t5_busy_n",  32'(busy_cnt), 32'd192);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case a wait is ever left unbounded.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
